// File: rtl/wd_service_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wd_service_generator_pkg
// Description : Shared definitions for the watchdog service front-end.
//               Holds the fault codes that are also reported by
//               wd_fail_detector, and the service FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package wd_service_generator_pkg;

    // Fault classes, shared with wd_fail_detector
    localparam logic [2:0] WD_FL_NONE   = 3'b000;
    localparam logic [2:0] WD_FL_OVR    = 3'b001;
    localparam logic [2:0] WD_FL_LOWSVC = 3'b010;
    localparam logic [2:0] WD_FL_DBLSVC = 3'b011;
    localparam logic [2:0] WD_FL_MISS   = 3'b100;

    // Service FSM states
    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,   // SWSTAT low, kicks are refused
        ST_OPEN  = 2'd1,   // window open, waiting for a kick
        ST_PULSE = 2'd2,   // WDSRVC being driven
        ST_SPENT = 2'd3    // window already serviced or missed
    } wd_state_e;

endpackage : wd_service_generator_pkg
`default_nettype wire

// File: rtl/wd_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : wd_sync_edge
// Description : Two-flop synchronizer for an asynchronous level, followed by
//               a one-flop edge detector. rise_o / fall_o are single-cycle
//               strobes derived purely from registers.
// Ports       : clk_i    - clock
//               rst_ni   - asynchronous active-low reset
//               async_i  - asynchronous level input
//               rise_o   - one cycle high after a synchronized 0->1
//               fall_o   - one cycle high after a synchronized 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module wd_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o =  sync_q & ~prev_q;
    assign fall_o = ~sync_q &  prev_q;

endmodule : wd_sync_edge
`default_nettype wire

// File: rtl/wd_service_generator.sv
`default_nettype none
// ============================================================================
// Module      : wd_service_generator
// Description : Watchdog servicing front-end. Turns asynchronous software
//               kick requests into at most one fixed-width WDSRVC pulse per
//               SWSTAT high window, refusing kicks the detector would flag
//               and reporting a missed window early.
// Ports       : CLK      - clock
//               RST_N    - asynchronous active-low reset
//               SWSTAT   - software-healthy window (asynchronous)
//               KICK_REQ - kick request level (asynchronous, rise = kick)
//               WDSRVC   - service pulse to wd_fail_detector
//               BUSY     - high while the service pulse is active
//               REJ      - one-cycle strobe, kick refused
//               REJ_CODE - fault code of the last refusal or miss
//               MISS     - one-cycle strobe, window ended unserviced
// Config      : WD_AUTO_SERVICE_EN - when defined, an unserviced window is
//               serviced autonomously at the latest legal start point.
// Revision    : 1.0 - initial release
// ============================================================================
module wd_service_generator
    import wd_service_generator_pkg::*;
#(
    parameter int PULSE_W  = 5,
    parameter int DEADLINE = 60,
    parameter int CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SWSTAT,
    input  logic       KICK_REQ,
    output logic       WDSRVC,
    output logic       BUSY,
    output logic       REJ,
    output logic [2:0] REJ_CODE,
    output logic       MISS
);

    localparam int c_pw_w = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    localparam logic [CNT_W-1:0]  c_deadline = CNT_W'(DEADLINE);
    // Last count at which a pulse can still finish inside the window
    localparam logic [CNT_W-1:0]  c_svc_last = CNT_W'(DEADLINE - PULSE_W);
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
    localparam logic [c_pw_w-1:0] c_pw_last  = c_pw_w'(PULSE_W - 1);
    localparam logic [c_pw_w-1:0] c_pw_one   = c_pw_w'(1);

    logic w_sw_rise;
    logic w_sw_fall;
    logic w_kick;
    logic w_kick_fall_unused;

    wd_sync_edge u_sync_sw (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .async_i (SWSTAT),
        .rise_o  (w_sw_rise),
        .fall_o  (w_sw_fall)
    );

    wd_sync_edge u_sync_kick (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .async_i (KICK_REQ),
        .rise_o  (w_kick),
        .fall_o  (w_kick_fall_unused)
    );

    wd_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [c_pw_w-1:0]  pcnt_q;      // remaining pulse cycles minus one
    logic               served_q;    // window ended in SPENT via a pulse
    logic               wdsrvc_q;
    logic               rej_q;
    logic               miss_q;
    logic [2:0]         code_q;

    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_in_time;
    logic               w_auto_now;

    // "Count" in the window rules is the value reached in this clock,
    // i.e. the incremented counter; it saturates at DEADLINE.
    assign w_cnt_nxt = (cnt_q == c_deadline) ? cnt_q : (cnt_q + c_cnt_one);
    assign w_in_time = (w_cnt_nxt <= c_svc_last);

`ifdef WD_AUTO_SERVICE_EN
    assign w_auto_now = (w_cnt_nxt == c_svc_last);
`else
    assign w_auto_now = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_LOW;
            cnt_q    <= '0;
            pcnt_q   <= '0;
            served_q <= 1'b0;
            wdsrvc_q <= 1'b0;
            rej_q    <= 1'b0;
            miss_q   <= 1'b0;
            code_q   <= WD_FL_NONE;
        end else begin
            rej_q  <= 1'b0;
            miss_q <= 1'b0;

            case (state_q)
                ST_LOW: begin
                    // A kick coinciding with the rise is still judged
                    // against the low window it was issued in.
                    if (w_kick) begin
                        rej_q  <= 1'b1;
                        code_q <= WD_FL_LOWSVC;
                    end
                    if (w_sw_rise) begin
                        state_q  <= ST_OPEN;
                        cnt_q    <= '0;
                        served_q <= 1'b0;
                    end
                end

                ST_OPEN: begin
                    cnt_q <= w_cnt_nxt;
                    if (w_sw_fall) begin
                        // Window closed early. A simultaneous kick is a
                        // low-window kick, which takes the single strobe.
                        state_q <= ST_LOW;
                        if (w_kick) begin
                            rej_q  <= 1'b1;
                            code_q <= WD_FL_LOWSVC;
                        end else begin
                            miss_q <= 1'b1;
                            code_q <= WD_FL_MISS;
                        end
                    end else if (w_kick && w_in_time) begin
                        state_q  <= ST_PULSE;
                        pcnt_q   <= c_pw_last;
                        wdsrvc_q <= 1'b1;
                        served_q <= 1'b1;
                    end else if (w_kick) begin
                        // Too late for the pulse to complete by DEADLINE
                        state_q  <= ST_SPENT;
                        served_q <= 1'b0;
                        rej_q    <= 1'b1;
                        code_q   <= WD_FL_MISS;
                    end else if (w_auto_now) begin
                        state_q  <= ST_PULSE;
                        pcnt_q   <= c_pw_last;
                        wdsrvc_q <= 1'b1;
                        served_q <= 1'b1;
                    end else if (w_cnt_nxt == c_deadline) begin
                        state_q  <= ST_SPENT;
                        served_q <= 1'b0;
                        miss_q   <= 1'b1;
                        code_q   <= WD_FL_MISS;
                    end
                end

                ST_PULSE: begin
                    cnt_q <= w_cnt_nxt;
                    if (w_sw_fall) begin
                        state_q  <= ST_LOW;
                        wdsrvc_q <= 1'b0;
                        rej_q    <= 1'b1;
                        code_q   <= WD_FL_LOWSVC;
                    end else begin
                        if (pcnt_q == '0) begin
                            state_q  <= ST_SPENT;
                            wdsrvc_q <= 1'b0;
                        end else begin
                            pcnt_q <= pcnt_q - c_pw_one;
                        end
                        if (w_kick) begin
                            rej_q  <= 1'b1;
                            code_q <= WD_FL_DBLSVC;
                        end
                    end
                end

                ST_SPENT: begin
                    cnt_q <= w_cnt_nxt;
                    if (w_sw_fall) begin
                        state_q <= ST_LOW;
                        if (w_kick) begin
                            rej_q  <= 1'b1;
                            code_q <= WD_FL_LOWSVC;
                        end
                    end else if (w_kick) begin
                        rej_q  <= 1'b1;
                        code_q <= served_q ? WD_FL_DBLSVC : WD_FL_MISS;
                    end
                end

                default: begin
                    state_q  <= ST_LOW;
                    wdsrvc_q <= 1'b0;
                end
            endcase
        end
    end

    assign WDSRVC   = wdsrvc_q;
    assign BUSY     = wdsrvc_q;
    assign REJ      = rej_q;
    assign MISS     = miss_q;
    assign REJ_CODE = code_q;

endmodule : wd_service_generator
`default_nettype wire

// File: tb/tb_wd_service_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wd_service_generator
// Description : Self-checking bench for wd_service_generator. Scenario table
//               of single windows with hand-derived expectations, a
//               mid-pulse reset sequence, and a randomized run checked
//               against a window-rule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wd_service_generator;
    import wd_service_generator_pkg::*;

    localparam int P  = 5;
    localparam int D  = 60;
    localparam int CW = 8;

`ifdef WD_AUTO_SERVICE_EN
    localparam bit AUTO_SVC = 1'b1;
`else
    localparam bit AUTO_SVC = 1'b0;
`endif

    logic       CLK      = 1'b0;
    logic       RST_N    = 1'b0;
    logic       SWSTAT   = 1'b0;
    logic       KICK_REQ = 1'b0;
    logic       WDSRVC;
    logic       BUSY;
    logic       REJ;
    logic       MISS;
    logic [2:0] REJ_CODE;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    wd_service_generator #(
        .PULSE_W  (P),
        .DEADLINE (D),
        .CNT_W    (CW)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .SWSTAT   (SWSTAT),
        .KICK_REQ (KICK_REQ),
        .WDSRVC   (WDSRVC),
        .BUSY     (BUSY),
        .REJ      (REJ),
        .REJ_CODE (REJ_CODE),
        .MISS     (MISS)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        RST_N    = 1'b0;
        SWSTAT   = 1'b0;
        KICK_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    // One window scenario: SWSTAT rises at offset 0 and stays high for
    // hi_len clocks; kicks are 2-clock KICK_REQ pulses at k1/k2 (-1 = none).
    // Offsets count clocks from the negedge the input is driven on.
    typedef struct {
        string name;
        int    hi_len;
        int    k1;
        int    k2;
        int    first;     // offset of first WDSRVC-high sample, -1 none
        int    width;     // WDSRVC-high samples
        int    nrej;
        int    code;      // REJ_CODE at end of scenario
        int    miss_at;   // offset of first MISS, -1 none
        int    nmiss;
    } vec_t;

    task automatic run_vec(input vec_t v, input bit with_reset,
                           output int first, output int width, output int nrej,
                           output int code, output int miss_at, output int nmiss);
        first = -1; width = 0; nrej = 0; miss_at = -1; nmiss = 0;
        if (with_reset) do_reset();
        for (int c = 0; c <= 110; c++) begin
            SWSTAT   = (c < v.hi_len);
            KICK_REQ = ((v.k1 >= 0) && (c >= v.k1) && (c < v.k1 + 2)) ||
                       ((v.k2 >= 0) && (c >= v.k2) && (c < v.k2 + 2));
            @(negedge CLK);
            if (WDSRVC) begin
                if (first < 0) first = c + 1;
                width++;
            end
            if (REJ) nrej++;
            if (MISS) begin
                if (miss_at < 0) miss_at = c + 1;
                nmiss++;
            end
        end
        code = int'(REJ_CODE);
    endtask

    // ------------------------------------------------------------------
    // Reference model: window rules expressed with an age counter, the
    // window outcome and the remaining pulse length. Inputs reach the
    // decision logic two clocks after being sampled; edges compare the
    // synchronized value with the one a clock older.
    // ------------------------------------------------------------------
    bit m_sw_h[4];
    bit m_kr_h[4];
    bit m_in_win;
    int m_age;
    int m_outcome;      // 0 = pending, 1 = serviced, 2 = missed
    int m_pulse_left;
    bit m_rej;
    bit m_miss;
    int m_code;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sw_h[i] = 1'b0;
            m_kr_h[i] = 1'b0;
        end
        m_in_win = 1'b0; m_age = 0; m_outcome = 0; m_pulse_left = 0;
        m_rej = 1'b0; m_miss = 1'b0; m_code = 0;
    endtask

    task automatic model_edge(input bit sw, input bit kr);
        bit rise, fall, kick;
        for (int i = 3; i > 0; i--) begin
            m_sw_h[i] = m_sw_h[i-1];
            m_kr_h[i] = m_kr_h[i-1];
        end
        m_sw_h[0] = sw;
        m_kr_h[0] = kr;
        rise = m_sw_h[2] & ~m_sw_h[3];
        fall = ~m_sw_h[2] & m_sw_h[3];
        kick = m_kr_h[2] & ~m_kr_h[3];
        m_rej  = 1'b0;
        m_miss = 1'b0;

        if (!m_in_win) begin
            if (kick) begin m_rej = 1'b1; m_code = 2; end
            if (rise) begin
                m_in_win = 1'b1; m_age = 0; m_outcome = 0; m_pulse_left = 0;
            end
        end else if (fall) begin
            m_in_win = 1'b0;
            if (m_pulse_left > 0) begin
                m_pulse_left = 0; m_rej = 1'b1; m_code = 2;
            end else if (kick) begin
                m_rej = 1'b1; m_code = 2;
            end else if (m_outcome == 0) begin
                m_miss = 1'b1; m_code = 4;
            end
        end else begin
            m_age = (m_age + 1 > D) ? D : m_age + 1;
            if (m_pulse_left > 0) begin
                m_pulse_left--;
                if (kick) begin m_rej = 1'b1; m_code = 3; end
            end else if (m_outcome == 0) begin
                if (kick && m_age <= D - P) begin
                    m_pulse_left = P; m_outcome = 1;
                end else if (kick) begin
                    m_rej = 1'b1; m_code = 4; m_outcome = 2;
                end else if (AUTO_SVC && m_age == D - P) begin
                    m_pulse_left = P; m_outcome = 1;
                end else if (m_age == D) begin
                    m_miss = 1'b1; m_code = 4; m_outcome = 2;
                end
            end else if (kick) begin
                m_rej = 1'b1; m_code = (m_outcome == 1) ? 3 : 4;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[$];
        int   first, width, nrej, code, miss_at, nmiss;
        bit   sw, kr;
        int   sw_left;
        int   act, exp;

        // -------------------- scenario table --------------------
        vt.push_back('{"kick20",     70, 20, -1, 23, 5, 0, int'(WD_FL_NONE),   -1, 0});
        vt.push_back('{"dbl30_55",   70, 30, 55, 33, 5, 1, int'(WD_FL_DBLSVC), -1, 0});
`ifdef WD_AUTO_SERVICE_EN
        vt.push_back('{"nokick",     70, -1, -1, 58, 5, 0, int'(WD_FL_NONE),   -1, 0});
        vt.push_back('{"late56",     70, 56, -1, 58, 5, 1, int'(WD_FL_DBLSVC), -1, 0});
`else
        vt.push_back('{"nokick",     70, -1, -1, -1, 0, 0, int'(WD_FL_MISS),   63, 1});
        vt.push_back('{"late56",     70, 56, -1, -1, 0, 1, int'(WD_FL_MISS),   -1, 0});
`endif
        vt.push_back('{"edge55",     70, 55, -1, 58, 5, 0, int'(WD_FL_NONE),   -1, 0});
        vt.push_back('{"lowkick",    70, 20, 80, 23, 5, 1, int'(WD_FL_LOWSVC), -1, 0});
        vt.push_back('{"fallpulse",  22, 20, -1, 23, 2, 1, int'(WD_FL_LOWSVC), -1, 0});
        vt.push_back('{"earlyclose", 30, -1, -1, -1, 0, 0, int'(WD_FL_MISS),   33, 1});
        vt.push_back('{"kickfall",   30, 30, -1, -1, 0, 1, int'(WD_FL_LOWSVC), -1, 0});
        vt.push_back('{"kickpulse",  70, 20, 23, 23, 5, 1, int'(WD_FL_DBLSVC), -1, 0});

        // -------------------- reset state --------------------
        RST_N = 1'b0;
        @(negedge CLK);
        check("reset_outputs", int'({WDSRVC, BUSY, REJ, MISS, REJ_CODE}), 0);

        foreach (vt[i]) begin
            run_vec(vt[i], 1'b1, first, width, nrej, code, miss_at, nmiss);
            check({vt[i].name, "_first"},   first,   vt[i].first);
            check({vt[i].name, "_width"},   width,   vt[i].width);
            check({vt[i].name, "_nrej"},    nrej,    vt[i].nrej);
            check({vt[i].name, "_code"},    code,    vt[i].code);
            check({vt[i].name, "_miss_at"}, miss_at, vt[i].miss_at);
            check({vt[i].name, "_nmiss"},   nmiss,   vt[i].nmiss);
        end

        // -------------------- reset in the middle of a pulse --------------------
        do_reset();
        for (int c = 0; c <= 23; c++) begin
            SWSTAT   = 1'b1;
            KICK_REQ = (c >= 20) && (c < 22);
            @(negedge CLK);
        end
        check("pulse_before_reset", int'(WDSRVC), 1);
        #2 RST_N = 1'b0;
        #1 check("async_reset_drop", int'({WDSRVC, BUSY, REJ, MISS, REJ_CODE}), 0);
        SWSTAT   = 1'b0;
        KICK_REQ = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        run_vec(vt[0], 1'b0, first, width, nrej, code, miss_at, nmiss);
        check("post_reset_first", first, 23);
        check("post_reset_width", width, 5);
        check("post_reset_nrej",  nrej,  0);
        check("post_reset_nmiss", nmiss, 0);

        // -------------------- randomized run against the model --------------------
        do_reset();
        model_reset();
        sw = 1'b0; kr = 1'b0; sw_left = 10;
        for (int c = 0; c < 4000; c++) begin
            if (sw_left == 0) begin
                sw = ~sw;
                sw_left = sw ? $urandom_range(10, 90) : $urandom_range(4, 40);
            end else begin
                sw_left--;
            end
            if ($urandom_range(0, 14) == 0) kr = ~kr;
            SWSTAT   = sw;
            KICK_REQ = kr;
            @(posedge CLK);
            model_edge(sw, kr);
            @(negedge CLK);
            act = int'({WDSRVC, BUSY, REJ, MISS, REJ_CODE});
            exp = ((m_pulse_left > 0) ? 96 : 0) + (m_rej ? 16 : 0) +
                  (m_miss ? 8 : 0) + m_code;
            check($sformatf("rand_cycle%0d {srv,busy,rej,miss,code}", c), act, exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_wd_service_generator
`default_nettype wire
